board_ctl: RTL and testbench

Game-board controller that turns mouse clicks into board state for the 3x3 tic-tac-toe grid. It sits directly upstream of the per-square drawing stages (`draw_square1`..`draw_square9`): it supplies each stage's `squareN` enable and owner colour select, and reports turn, game-over and winner to the rest of the game logic. It runs entirely in the `pclk` domain, and mouse inputs are already synchronous to `pclk`.

---
 rtl/board_pkg.sv | 51 +++++
 rtl/board_win_check.sv | 38 +++
 rtl/board_ctl.sv | 161 ++++++++++++++++
 tb/tb_board_ctl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the tic-tac-toe board controller.
// Holds grid boundary constants, the controller FSM encoding, winner codes
// and the table of the eight winning lines.
package board_pkg;

  // Column pixel boundaries (inclusive); the pixels between them are gaps.
  localparam logic [11:0] COL0_MIN = 12'd0;
  localparam logic [11:0] COL0_MAX = 12'd340;
  localparam logic [11:0] COL1_MIN = 12'd343;
  localparam logic [11:0] COL1_MAX = 12'd682;
  localparam logic [11:0] COL2_MIN = 12'd685;
  localparam logic [11:0] COL2_MAX = 12'd1023;

  // Row pixel boundaries (inclusive).
  localparam logic [11:0] ROW0_MIN = 12'd0;
  localparam logic [11:0] ROW0_MAX = 12'd252;
  localparam logic [11:0] ROW1_MIN = 12'd257;
  localparam logic [11:0] ROW1_MAX = 12'd510;
  localparam logic [11:0] ROW2_MIN = 12'd515;
  localparam logic [11:0] ROW2_MAX = 12'd767;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P0   = 2'b01,
    WIN_P1   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Square masks of the 8 lines: 3 rows, 3 columns, 2 diagonals.
  // Bit k corresponds to square k+1 (row-major from top-left).
  function automatic logic [8:0] line_mask(input logic [2:0] k);
    case (k)
      3'd0:    line_mask = 9'b000_000_111;
      3'd1:    line_mask = 9'b000_111_000;
      3'd2:    line_mask = 9'b111_000_000;
      3'd3:    line_mask = 9'b001_001_001;
      3'd4:    line_mask = 9'b010_010_010;
      3'd5:    line_mask = 9'b100_100_100;
      3'd6:    line_mask = 9'b100_010_001;
      default: line_mask = 9'b001_010_100;
    endcase
  endfunction

endpackage

// File: rtl/board_win_check.sv
// Combinational board evaluator.
// Ports: occ/owner (9-bit board) in; win, win_player (owner of the
// completed line) and full (all 9 squares occupied) out.
module board_win_check
  import board_pkg::*;
(
  input  logic [8:0] occ,
  input  logic [8:0] owner,
  output logic       win,
  output logic       win_player,
  output logic       full
);

  logic [8:0] m;

  always_comb begin
    win        = 1'b0;
    win_player = 1'b0;
    m          = 9'd0;
    for (int k = 0; k < 8; k++) begin
      m = line_mask(3'(k));
      // A line counts only when all three squares are occupied and the
      // owner bits agree (all ones or all zeros).
      if (!win && ((occ & m) == m)) begin
        if ((owner & m) == m) begin
          win        = 1'b1;
          win_player = 1'b1;
        end else if ((owner & m) == 9'd0) begin
          win        = 1'b1;
          win_player = 1'b0;
        end
      end
    end
  end

  assign full = &occ;

endmodule

// File: rtl/board_ctl.sv
// Tic-tac-toe board controller: mouse clicks -> board occupancy/owner,
// turn, game_over and winner. Ports: pclk/rst, mouse_xpos/ypos/left,
// start_en, choice_en, new_game in; square_occ/owner, turn, game_over, winner out.
// Optional macro BOARD_WIN_DETECT_EN enables line-win detection; without it
// the game only ends as a draw on a full board.
module board_ctl
  import board_pkg::*;
#(
  parameter int XRES = 1024,
  parameter int YRES = 768
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        start_en,
  input  logic        choice_en,
  input  logic        new_game,
  output logic [8:0]  square_occ,
  output logic [8:0]  square_owner,
  output logic        turn,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [11:0] X_LAST = 12'(XRES - 1);
  localparam logic [11:0] Y_LAST = 12'(YRES - 1);

  state_t     state, state_nxt;
  logic       mouse_left_d;
  logic       click, enabled;
  logic [1:0] col, row;
  logic       col_vld, row_vld;
  logic [3:0] sq_idx;
  logic [8:0] sq_bit;
  logic       sq_empty;
  logic       place, clear, finish;
  logic       win, win_player, full;
  logic       result_hit;
  winner_t    result_code;

  assign click   = mouse_left & ~mouse_left_d;
  assign enabled = start_en & ~choice_en;

  // Pixel -> grid decode; gap pixels and off-screen coordinates miss.
  always_comb begin
    col     = 2'd0;
    col_vld = 1'b0;
    if (mouse_xpos <= COL0_MAX) begin
      col = 2'd0; col_vld = 1'b1;
    end else if (mouse_xpos >= COL1_MIN && mouse_xpos <= COL1_MAX) begin
      col = 2'd1; col_vld = 1'b1;
    end else if (mouse_xpos >= COL2_MIN && mouse_xpos <= COL2_MAX && mouse_xpos <= X_LAST) begin
      col = 2'd2; col_vld = 1'b1;
    end
  end

  always_comb begin
    row     = 2'd0;
    row_vld = 1'b0;
    if (mouse_ypos <= ROW0_MAX) begin
      row = 2'd0; row_vld = 1'b1;
    end else if (mouse_ypos >= ROW1_MIN && mouse_ypos <= ROW1_MAX) begin
      row = 2'd1; row_vld = 1'b1;
    end else if (mouse_ypos >= ROW2_MIN && mouse_ypos <= ROW2_MAX && mouse_ypos <= Y_LAST) begin
      row = 2'd2; row_vld = 1'b1;
    end
  end

  assign sq_idx   = 4'({2'b00, row} * 4'd3) + {2'b00, col};
  assign sq_bit   = (col_vld && row_vld) ? (9'd1 << sq_idx) : 9'd0;
  assign sq_empty = (sq_bit != 9'd0) && ((square_occ & sq_bit) == 9'd0);

  board_win_check u_win_check (
    .occ        (square_occ),
    .owner      (square_owner),
    .win        (win),
    .win_player (win_player),
    .full       (full)
  );

`ifdef BOARD_WIN_DETECT_EN
  // A win on the final move takes precedence over the draw.
  assign result_hit  = win | full;
  assign result_code = win ? (win_player ? WIN_P1 : WIN_P0) : WIN_DRAW;
`else
  logic unused_win;
  assign unused_win  = win ^ win_player;
  assign result_hit  = full;
  assign result_code = WIN_DRAW;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    place     = 1'b0;
    clear     = 1'b0;
    finish    = 1'b0;
    if (new_game) begin
      // Clearing wins over any click in the same cycle.
      clear     = 1'b1;
      state_nxt = enabled ? ST_PLAY : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (enabled) state_nxt = ST_PLAY;
        ST_PLAY: begin
          if (!enabled) begin
            state_nxt = ST_IDLE;
          end else if (click && sq_empty) begin
            place     = 1'b1;
            state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (result_hit) begin
            finish    = 1'b1;
            state_nxt = ST_OVER;
          end else begin
            state_nxt = ST_PLAY;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      mouse_left_d <= 1'b0;
      square_occ   <= 9'd0;
      square_owner <= 9'd0;
      turn         <= 1'b0;
      game_over    <= 1'b0;
      winner       <= WIN_NONE;
    end else begin
      // The edge detector tracks the button in every state, so presses
      // outside PLAY are consumed rather than queued.
      mouse_left_d <= mouse_left;
      if (clear) begin
        square_occ   <= 9'd0;
        square_owner <= 9'd0;
        turn         <= 1'b0;
        game_over    <= 1'b0;
        winner       <= WIN_NONE;
      end else if (place) begin
        square_occ   <= square_occ | sq_bit;
        square_owner <= turn ? (square_owner | sq_bit) : (square_owner & ~sq_bit);
        turn         <= ~turn;
      end else if (finish) begin
        game_over <= 1'b1;
        winner    <= result_code;
      end
    end
  end

endmodule

// File: tb/tb_board_ctl.sv
// Bench for board_ctl: boundary-decode table, directed game sequences and a
// randomized run, all checked against a square-array reference model.
module tb_board_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] mx, my;
  logic        ml, se, ce, ng;
  logic [8:0]  square_occ, square_owner;
  logic        turn, game_over;
  logic [1:0]  winner;

  int checks   = 0;
  int failures = 0;

  board_ctl #(.XRES(1024), .YRES(768)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .mouse_xpos   (mx),
    .mouse_ypos   (my),
    .mouse_left   (ml),
    .start_en     (se),
    .choice_en    (ce),
    .new_game     (ng),
    .square_occ   (square_occ),
    .square_owner (square_owner),
    .turn         (turn),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 pclk = ~pclk;

  // ---------------- reference model ----------------
  int m_board [9];       // -1 empty, else owning player
  int m_turn, m_winner;
  bit m_over, m_check, m_active, m_ml_d;
  int lines [8][3];

  function automatic int coord_band(int v, int a0, int a1, int b0, int b1, int c0, int c1);
    if (v >= a0 && v <= a1) return 0;
    if (v >= b0 && v <= b1) return 1;
    if (v >= c0 && v <= c1) return 2;
    return -1;
  endfunction

  function automatic int sq_of(int x, int y);
    int c, r;
    c = coord_band(x, 0, 340, 343, 682, 685, 1023);
    r = coord_band(y, 0, 252, 257, 510, 515, 767);
    if (c < 0 || r < 0) return -1;
    return 3 * r + c;
  endfunction

  task automatic model_reset();
    foreach (m_board[i]) m_board[i] = -1;
    m_turn = 0; m_winner = 0; m_over = 0; m_check = 0; m_active = 0; m_ml_d = 0;
  endtask

  task automatic model_judge();
    int filled;
    int w;
    filled = 0;
    w = -1;
    foreach (m_board[i]) if (m_board[i] >= 0) filled++;
`ifdef BOARD_WIN_DETECT_EN
    for (int l = 0; l < 8; l++) begin
      int a, b, c;
      a = m_board[lines[l][0]]; b = m_board[lines[l][1]]; c = m_board[lines[l][2]];
      if (w < 0 && a >= 0 && a == b && b == c) w = a;
    end
`endif
    if (w >= 0) begin
      m_over = 1; m_winner = w + 1;
    end else if (filled == 9) begin
      m_over = 1; m_winner = 3;
    end
  endtask

  task automatic model_step();
    bit click, en;
    int sq;
    click  = ml && !m_ml_d;
    m_ml_d = ml;
    en     = se && !ce;
    sq     = sq_of(int'(mx), int'(my));
    if (ng) begin
      foreach (m_board[i]) m_board[i] = -1;
      m_turn = 0; m_winner = 0; m_over = 0; m_check = 0; m_active = en;
    end else if (m_over) begin
    end else if (m_check) begin
      m_check = 0;
      model_judge();
    end else if (!m_active) begin
      m_active = en;
    end else if (!en) begin
      m_active = 0;
    end else if (click && sq >= 0 && m_board[sq] < 0) begin
      m_board[sq] = m_turn;
      m_turn      = 1 - m_turn;
      m_check     = 1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_model(string name);
    logic [8:0] eo, ew;
    eo = 9'd0; ew = 9'd0;
    foreach (m_board[i]) begin
      if (m_board[i] >= 0) eo[i] = 1'b1;
      if (m_board[i] == 1) ew[i] = 1'b1;
    end
    chk(name, int'({square_occ, square_owner, turn, game_over, winner}),
              int'({eo, ew, m_turn[0], m_over, m_winner[1:0]}));
  endtask

  task automatic tick();
    @(posedge pclk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_model("model");
  endtask

  task automatic click_at(int x, int y);
    mx = 12'(x); my = 12'(y);
    ml = 1'b1; tick();
    ml = 1'b0; tick();
  endtask

  task automatic click_sq(int s);
    click_at((s % 3) * 342 + 170, (s / 3) * 256 + 126);
  endtask

  task automatic fresh_game();
    ng = 1'b1; tick();
    ng = 1'b0; tick();
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [8:0] occ;
  } vec_t;

  vec_t vecs [21];
  int   draw_seq [9];

  initial begin
    lines[0] = '{0,1,2}; lines[1] = '{3,4,5}; lines[2] = '{6,7,8};
    lines[3] = '{0,3,6}; lines[4] = '{1,4,7}; lines[5] = '{2,5,8};
    lines[6] = '{0,4,8}; lines[7] = '{2,4,6};

    vecs[0]  = '{340,   0, 9'h001}; vecs[1]  = '{341,   0, 9'h000};
    vecs[2]  = '{342,   0, 9'h000}; vecs[3]  = '{343,   0, 9'h002};
    vecs[4]  = '{682, 252, 9'h002}; vecs[5]  = '{683, 100, 9'h000};
    vecs[6]  = '{684, 100, 9'h000}; vecs[7]  = '{685, 100, 9'h004};
    vecs[8]  = '{1023,767, 9'h100}; vecs[9]  = '{1024,100, 9'h000};
    vecs[10] = '{100, 253, 9'h000}; vecs[11] = '{100, 256, 9'h000};
    vecs[12] = '{100, 257, 9'h008}; vecs[13] = '{100, 510, 9'h008};
    vecs[14] = '{100, 511, 9'h000}; vecs[15] = '{100, 514, 9'h000};
    vecs[16] = '{100, 515, 9'h040}; vecs[17] = '{100, 767, 9'h040};
    vecs[18] = '{100, 768, 9'h000}; vecs[19] = '{500, 400, 9'h010};
    vecs[20] = '{4095,4095,9'h000};

    // Drawn game (squares numbered 0..8): no line completes for either side.
    draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    model_reset();
    rst = 1'b1; mx = 12'd0; my = 12'd0; ml = 1'b0; se = 1'b0; ce = 1'b0; ng = 1'b0;
    #12;
    chk("reset_outputs", int'({square_occ, square_owner, turn, game_over, winner}), 0);
    tick();
    rst = 1'b0;

    // First click at (800,600) -> square9, player0, turn flips.
    se = 1'b1; tick();
    mx = 12'd800; my = 12'd600; ml = 1'b1; tick();
    chk("first_click_occ", int'(square_occ), 'h100);
    chk("first_click_owner8", int'(square_owner[8]), 0);
    chk("first_click_turn", int'(turn), 1);
    ml = 1'b0; tick(); tick();

    // Gap click then click on the occupied square: nothing changes.
    click_at(342, 100);
    chk("gap_click_occ", int'({square_occ, turn}), int'({9'h100, 1'b1}));
    click_at(800, 600);
    chk("occupied_click", int'({square_occ, square_owner, turn}), int'({9'h100, 9'h000, 1'b1}));

    // Held button over square1 places exactly once.
    fresh_game();
    mx = 12'd100; my = 12'd100; ml = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    ml = 1'b0; tick();
    chk("hold_single_place", int'({square_occ, turn}), int'({9'h001, 1'b1}));

    // Boundary decode table.
    foreach (vecs[i]) begin
      fresh_game();
      click_at(vecs[i].x, vecs[i].y);
      chk($sformatf("decode_%0d_%0d", vecs[i].x, vecs[i].y), int'(square_occ), int'(vecs[i].occ));
    end

    // Diagonal win for player0: 1(p0) 2(p1) 5(p0) 3(p1) 9(p0).
    fresh_game();
    click_sq(0); click_sq(1); click_sq(4); click_sq(2);
    click_sq(8);
`ifdef BOARD_WIN_DETECT_EN
    chk("diag_win", int'({game_over, winner}), int'({1'b1, 2'b01}));
`else
    chk("diag_no_win", int'({game_over, winner}), int'({1'b0, 2'b00}));
`endif
    click_at(500, 400);
    chk("after_win_click", int'({square_occ, turn}), int'({9'h117, 1'b1}));

    // Full board without a line -> draw right after the 9th placement.
    fresh_game();
    for (int i = 0; i < 9; i++) click_sq(draw_seq[i]);
    chk("draw_result", int'({square_occ, game_over, winner}), int'({9'h1FF, 1'b1, 2'b11}));

    // new_game coincident with a click on an empty square.
    fresh_game();
    click_sq(0);
    mx = 12'd500; my = 12'd400; ml = 1'b1; ng = 1'b1; tick();
    chk("newgame_vs_click", int'({square_occ, square_owner, turn}), 0);
    ng = 1'b0; ml = 1'b0; tick();

    // Asynchronous reset mid-game.
    click_sq(3); click_sq(4);
    rst = 1'b1; #1;
    chk("async_reset", int'({square_occ, square_owner, turn, game_over, winner}), 0);
    tick();
    rst = 1'b0; tick();

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      ng = ($urandom_range(99) < 2);
      if ($urandom_range(99) < 3) se = ~se;
      if ($urandom_range(99) < 3) ce = ~ce;
      if ($urandom_range(99) < 40) ml = ~ml;
      if ($urandom_range(99) < 80) begin
        mx = 12'($urandom_range(2) * 342 + 170);
        my = 12'($urandom_range(2) * 256 + 126);
      end else begin
        mx = 12'($urandom_range(1100));
        my = 12'($urandom_range(850));
      end
      if (se == 1'b0 && $urandom_range(99) < 20) se = 1'b1;
      if (ce == 1'b1 && $urandom_range(99) < 20) ce = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
